// File: rtl/product_accumulator_if.sv
// Term-in / frame-result-out bundle for product_accumulator.
// ACC_W and MAX_TERMS must match the parameters of the attached product_accumulator.
interface product_accumulator_if #(
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 16
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    // Handshake rule, both sides: a beat transfers on a rising clk edge where
    // valid & ready are both 1. The producer holds its data and valid stable until
    // that edge, and valid never depends combinationally on ready.
    logic [7:0]       p_in;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] term_cnt;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  p_in,
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output acc_out,
        output term_cnt,
        output ovf,
        output out_valid
    );

    modport master (
        output p_in,
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  acc_out,
        input  term_cnt,
        input  ovf,
        input  out_valid
    );
endinterface

// File: rtl/product_accumulator.sv
// Saturating accumulator for a frame of 8-bit unsigned products.
// It presents the frame total, the term count and a sticky overflow flag on a valid/ready result port.
module product_accumulator #(
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    product_accumulator_if.slave    bus,
    output logic                    state_o
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             out_valid_q;
    logic [ACC_W:0]   sum_wide;
    logic             sat;
    logic             close;

    // The sum is one bit wider than the accumulator so the carry out flags saturation.
    always_comb begin
        sum_wide = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, bus.p_in};
        sat      = sum_wide[ACC_W];
        acc_d    = sat ? ACC_MAX : sum_wide[ACC_W-1:0];
        cnt_d    = cnt_q + 1'b1;
        close    = bus.in_last || (cnt_d == MAX_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (bus.in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_q | sat;
                        if (close) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Retiring returns to ACC; the next term is taken one cycle later.
                    if (bus.out_ready) begin
                        state_q     <= ST_ACC;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_ACC;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.acc_out   = acc_q;
    assign bus.term_cnt  = cnt_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed and multiplier-driven checks of product_accumulator at the default size,
// plus a 9-bit instance that exercises saturation.
module tb_product_accumulator;
    logic clk;
    logic rst;
    logic state12;
    logic state9;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [4:0]  exp_cnt_q[$];

    product_accumulator_if #(.ACC_W(12), .MAX_TERMS(16)) bus ();
    product_accumulator_if #(.ACC_W(9),  .MAX_TERMS(16)) bus9 ();

    product_accumulator #(.ACC_W(12), .MAX_TERMS(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state12)
    );

    product_accumulator #(.ACC_W(9), .MAX_TERMS(16)) dut9 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus9),
        .state_o (state9)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [7:0] p, input logic last);
        bus.p_in     = p;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic beat9(input logic [7:0] p, input logic last);
        bus9.p_in     = p;
        bus9.in_valid = 1'b1;
        bus9.in_last  = last;
        tick();
        bus9.in_valid = 1'b0;
        bus9.in_last  = 1'b0;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // ---------------- stimulus and scoreboard ----------------
    initial begin
        logic [3:0]  a;
        logic [3:0]  b;
        int          nterms;
        int          ref_sum;
        int          wait_cyc;
        logic [11:0] exp_sum;
        logic [4:0]  exp_cnt;

        rst = 1'b1;
        bus.p_in = '0;  bus.in_valid = 1'b0;  bus.in_last = 1'b0;  bus.out_ready = 1'b0;
        bus9.p_in = '0; bus9.in_valid = 1'b0; bus9.in_last = 1'b0; bus9.out_ready = 1'b0;
        #2;
        check("rst_acc", bus.acc_out, 0);
        check("rst_cnt", bus.term_cnt, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_state", state12, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Test 1: basic frame
        beat(8'd225, 1'b0);
        beat(8'd15, 1'b0);
        check("t1_mid_acc", bus.acc_out, 240);
        check("t1_mid_valid", bus.out_valid, 0);
        beat(8'd0, 1'b1);
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_acc", bus.acc_out, 240);
        check("t1_cnt", bus.term_cnt, 3);
        check("t1_ovf", bus.ovf, 0);
        check("t1_in_ready", bus.in_ready, 0);
        check("t1_state", state12, 1);

        // Test 2: backpressure; the offered term must be ignored
        bus.p_in = 8'd7;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", bus.out_valid, 1);
            check("t2_hold_acc", bus.acc_out, 240);
            check("t2_hold_cnt", bus.term_cnt, 3);
            check("t2_hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        retire();
        check("t2_ret_valid", bus.out_valid, 0);
        check("t2_ret_acc", bus.acc_out, 0);
        check("t2_ret_cnt", bus.term_cnt, 0);
        check("t2_ret_in_ready", bus.in_ready, 1);

        // Test 3: auto-close at MAX_TERMS
        for (int i = 0; i < 15; i++) beat(8'd225, 1'b0);
        check("t3_15_valid", bus.out_valid, 0);
        check("t3_15_cnt", bus.term_cnt, 15);
        check("t3_15_acc", bus.acc_out, 3375);
        beat(8'd225, 1'b0);
        check("t3_valid", bus.out_valid, 1);
        check("t3_acc", bus.acc_out, 3600);
        check("t3_cnt", bus.term_cnt, 16);
        check("t3_ovf", bus.ovf, 0);
        retire();

        // Test 4: saturation on the 9-bit instance
        beat9(8'd225, 1'b0);
        beat9(8'd225, 1'b0);
        check("t4_mid_acc", bus9.acc_out, 450);
        check("t4_mid_ovf", bus9.ovf, 0);
        beat9(8'd225, 1'b1);
        check("t4_valid", bus9.out_valid, 1);
        check("t4_acc", bus9.acc_out, 511);
        check("t4_ovf", bus9.ovf, 1);
        check("t4_cnt", bus9.term_cnt, 3);
        bus9.out_ready = 1'b1;
        tick();
        bus9.out_ready = 1'b0;
        check("t4_ret_ovf", bus9.ovf, 0);
        check("t4_ret_acc", bus9.acc_out, 0);
        check("t4_ret_valid", bus9.out_valid, 0);

        // Test 5: gaps, and in_last on an invalid cycle
        beat(8'd10, 1'b0);
        bus.p_in = 8'd200;
        bus.in_last = 1'b1;
        tick();
        bus.in_last = 1'b0;
        check("t5_gap_valid", bus.out_valid, 0);
        check("t5_gap_acc", bus.acc_out, 10);
        beat(8'd20, 1'b0);
        tick();
        beat(8'd5, 1'b1);
        check("t5_valid", bus.out_valid, 1);
        check("t5_acc", bus.acc_out, 35);
        check("t5_cnt", bus.term_cnt, 3);
        retire();

        // Test 6: reset mid-frame
        for (int i = 0; i < 3; i++) beat(8'd100, 1'b0);
        check("t6_pre_acc", bus.acc_out, 300);
        rst = 1'b1;
        #1;
        check("t6_rst_acc", bus.acc_out, 0);
        check("t6_rst_cnt", bus.term_cnt, 0);
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_in_ready", bus.in_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        beat(8'd1, 1'b0);
        beat(8'd2, 1'b1);
        check("t6_valid", bus.out_valid, 1);
        check("t6_acc", bus.acc_out, 3);
        check("t6_cnt", bus.term_cnt, 2);
        retire();

        // End-to-end: behavioural 4x4 multiplier feeding random frames
        for (int f = 0; f < 6; f++) begin
            nterms = $urandom_range(1, 16);
            ref_sum = 0;
            for (int t = 0; t < nterms; t++) begin
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                ref_sum += int'(a) * int'(b);
                if ($urandom_range(0, 3) == 0) tick();
                beat(8'(a * b), (t == nterms - 1) ? 1'b1 : 1'b0);
            end
            exp_q.push_back(12'(ref_sum));
            exp_cnt_q.push_back(5'(nterms));
            wait_cyc = 0;
            while (!bus.out_valid && wait_cyc < 20) begin
                tick();
                wait_cyc++;
            end
            check("e2e_out_valid", bus.out_valid, 1);
            exp_sum = exp_q.pop_front();
            exp_cnt = exp_cnt_q.pop_front();
            check("e2e_acc", bus.acc_out, exp_sum);
            check("e2e_cnt", bus.term_cnt, exp_cnt);
            check("e2e_ovf", bus.ovf, 0);
            retire();
        end

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
